ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS32 pipeline.
- Consumes the decoded operation (aluop/alusel, two 32-bit operands, destination register, write enable) from the ID/EX register.
- Produces the write-back triple. The decode stage uses this triple for EX->ID forwarding, and the EX/MEM register latches it.
- Owns the HI/LO registers and an iterative 32-cycle divider, which requests a pipeline stall while it is busy.

Parameters:
- DIV_CYCLES, 32, number of quotient iterations (one bit per cycle); must equal the data width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill the current instruction: abort the divider, no HI/LO write, ex_wr_en forced 0
- aluop_i  in  8  operation code
- alusel_i  in  3  result class
- reg1_i  in  32  operand 1 (source for the shift amount, dividend, multiplicand)
- reg2_i  in  32  operand 2 (shifted value, divisor, multiplier)
- waddr_i  in  5  destination GPR
- wr_en_i  in  1  GPR write request from decode
- ex_wr_en  out  1  GPR write enable (combinational)
- ex_wdata  out  32  GPR write data (combinational)
- ex_waddr  out  5  GPR address (combinational, equals waddr_i)
- stall_req  out  1  hold IF/ID/EX; upstream keeps the inputs constant while this is high
- hi_o  out  32  current HI (registered)
- lo_o  out  32  current LO (registered)

Behaviour:
- Encodings, aluop:
  - NOP 00000000
  - AND 00100100, OR 00100101, XOR 00100110, NOR 00100111
  - SLL 01111100, SRL 00000010, SRA 00000011
  - ADDU 00100001, SUBU 00100011, SLT 00101010, SLTU 00101011
  - MFHI 00010000, MTHI 00010001, MFLO 00010010, MTLO 00010011
  - MULT 00011000, MULTU 00011001, DIV 00011010, DIVU 00011011
- Encodings, alusel: NOP 000, LOGIC 001, SHIFT 010, MOVE 011, ARITH 100.
- Reset: while rst=1, every output is 0. At the clock edge: HI=LO=0, FSM=IDLE, counter=0.
- Combinational results, selected by alusel:
  - LOGIC: bitwise AND / OR / XOR / NOR.
  - SHIFT: reg2_i shifted by reg1_i[4:0]; SRA sign-fills.
  - ARITH: ADDU/SUBU wrap modulo 2^32 with no overflow trap. SLT is a signed compare, SLTU an unsigned compare; each yields 1 or 0.
  - MOVE: MFHI/MFLO return the current HI/LO.
  - Unknown op or NOP: ex_wdata=0.
- ex_wr_en = wr_en_i && !flush && !rst. It is 0 for MULT/MULTU/DIV/DIVU/MTHI/MTLO regardless of wr_en_i.
- HI/LO writes, at the rising edge, only when flush=0:
  - MULT/MULTU: {HI,LO} = 64-bit signed/unsigned product; single cycle, no stall.
  - MTHI: HI=reg1_i. MTLO: LO=reg1_i.
  - DIV/DIVU: LO=quotient, HI=remainder, written only on the DONE cycle.
  - MFHI issued in the cycle after MULT sees the new HI.
- Divider FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If aluop is DIV/DIVU, flush=0 and divisor != 0: latch the operands and stall_req=1. For signed DIV, latch absolute values and the result signs. Set counter=0 and go to BUSY.
  - If the divisor is 0: stall_req=1, go to DONE with quotient=FFFFFFFF and remainder=dividend.
- BUSY: one restoring-division step per cycle; stall_req=1. Go to DONE after DIV_CYCLES steps.
- DONE: stall_req=0. For signed ops, negate the quotient if the operand signs differ, and make the remainder take the dividend's sign. Write HI/LO at the edge and go to IDLE; the upstream advances on the same edge.
- Latency: a nonzero-divisor divide stalls 33 cycles and occupies 34 cycles. A divide by zero stalls 1 cycle.
- Edge cases:
  - INT_MIN / -1 (signed): quotient 80000000, remainder 0.
  - DIVU treats all operands as unsigned.
  - The FSM decides what to do from aluop_i only in IDLE. Inputs changing during BUSY are ignored because stall guarantees they are stable.
  - flush in any state: next state IDLE, stall_req=0 in that cycle, no HI/LO write.
  - rst in BUSY: IDLE at the next edge; HI/LO cleared.

Test Plan:
- Reset, then idle: rst high 2 cycles, then NOP -> ex_wr_en=0, ex_wdata=0, hi_o=lo_o=0, stall_req=0.
- ALU ops:
  - OR 0000F0F0|00000F0F, wr_en_i=1, waddr 5 -> ex_wdata=0000FFFF, ex_waddr=5.
  - SRA of 80000000 by 4 -> F8000000.
  - SLT FFFFFFFF,1 -> 1; SLTU same operands -> 0.
- MULT and moves:
  - MULT FFFFFFFE x 3 -> next cycle HI=FFFFFFFF, LO=FFFFFFFA. MULTU same operands -> HI=00000002, LO=FFFFFFFA.
  - MTLO 1234, then MFLO -> ex_wdata=00001234.
- Signed divide:
  - DIV -7 / 2 -> stall_req high exactly 33 cycles, then LO=FFFFFFFD, HI=FFFFFFFF.
  - DIVU 100/7 -> LO=14, HI=2.
  - DIV 80000000 / FFFFFFFF -> LO=80000000, HI=0.
- Divide by zero: DIV 5/0 -> stall_req high 1 cycle; LO=FFFFFFFF, HI=5.
- Abort:
  - flush asserted at BUSY cycle 10 -> stall_req drops that cycle, HI/LO unchanged, FSM IDLE.
  - rst mid-BUSY -> HI=LO=0, stall_req=0.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: MIPS32 execute stage with ALU, HI/LO registers and a restoring divider that stalls the pipeline
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  waddr_i,
  input  logic        wr_en_i,
  output logic        ex_wr_en,
  output logic [31:0] ex_wdata,
  output logic [4:0]  ex_waddr,
  output logic        stall_req,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam logic [7:0] OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26, OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
  localparam logic [7:0] OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_SLT = 8'h2A, OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_MFHI = 8'h10, OP_MTHI = 8'h11, OP_MFLO = 8'h12, OP_MTLO = 8'h13;
  localparam logic [7:0] OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;
  localparam logic [2:0] SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_MOVE = 3'd3, SEL_ARITH = 3'd4;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [31:0] quot_q, quot_d, rem_q, rem_d, dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
  logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic [4:0] sh;
  logic [31:0] logic_r, shift_r, arith_r, move_r, sra_r, a_abs, b_abs, q_fin, r_fin;
  logic [63:0] prod;
  logic [32:0] r33, diff;
  logic is_div, sdiv, is_mul, no_gpr, stall;
  assign sh = reg1_i[4:0];
  assign sra_r = (reg2_i >> sh) | ({32{reg2_i[31]}} & ~(32'hFFFF_FFFF >> sh));
  assign logic_r = aluop_i == OP_AND ? reg1_i & reg2_i :
                   aluop_i == OP_OR  ? reg1_i | reg2_i :
                   aluop_i == OP_XOR ? reg1_i ^ reg2_i :
                   aluop_i == OP_NOR ? ~(reg1_i | reg2_i) : 32'd0;
  assign shift_r = aluop_i == OP_SLL ? reg2_i << sh :
                   aluop_i == OP_SRL ? reg2_i >> sh :
                   aluop_i == OP_SRA ? sra_r : 32'd0;
  assign arith_r = aluop_i == OP_ADDU ? reg1_i + reg2_i :
                   aluop_i == OP_SUBU ? reg1_i - reg2_i :
                   aluop_i == OP_SLT  ? {31'd0, $signed(reg1_i) < $signed(reg2_i)} :
                   aluop_i == OP_SLTU ? {31'd0, reg1_i < reg2_i} : 32'd0;
  assign move_r = aluop_i == OP_MFHI ? hi_q : aluop_i == OP_MFLO ? lo_q : 32'd0;
  assign ex_wdata = rst ? 32'd0 :
                    alusel_i == SEL_LOGIC ? logic_r :
                    alusel_i == SEL_SHIFT ? shift_r :
                    alusel_i == SEL_MOVE  ? move_r :
                    alusel_i == SEL_ARITH ? arith_r : 32'd0;
  assign is_div = aluop_i == OP_DIV || aluop_i == OP_DIVU;
  assign sdiv = aluop_i == OP_DIV;
  assign is_mul = aluop_i == OP_MULT || aluop_i == OP_MULTU;
  assign no_gpr = is_div || is_mul || aluop_i == OP_MTHI || aluop_i == OP_MTLO;
  assign ex_wr_en = wr_en_i && !flush && !rst && !no_gpr;
  assign ex_waddr = rst ? 5'd0 : waddr_i;
  assign stall_req = stall && !rst;
  assign hi_o = rst ? 32'd0 : hi_q;
  assign lo_o = rst ? 32'd0 : lo_q;
  assign prod = aluop_i == OP_MULT ? {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i}
                                   : {32'd0, reg1_i} * {32'd0, reg2_i};
  assign a_abs = sdiv && reg1_i[31] ? -reg1_i : reg1_i;
  assign b_abs = sdiv && reg2_i[31] ? -reg2_i : reg2_i;
  assign r33 = {rem_q, quot_q[31]};
  assign diff = r33 - {1'b0, dvs_q};
  assign q_fin = neg_q_q ? -quot_q : quot_q;
  assign r_fin = neg_r_q ? -rem_q : rem_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    quot_d = quot_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    hi_d = hi_q;
    lo_d = lo_q;
    stall = 1'b0;
    if (flush) state_d = IDLE;
    else case (state_q)
      IDLE: begin
        if (is_mul) {hi_d, lo_d} = prod;
        if (aluop_i == OP_MTHI) hi_d = reg1_i;
        if (aluop_i == OP_MTLO) lo_d = reg1_i;
        if (is_div) begin
          stall = 1'b1;
          cnt_d = 6'd0;
          quot_d = reg2_i == 32'd0 ? 32'hFFFF_FFFF : a_abs;
          rem_d = reg2_i == 32'd0 ? reg1_i : 32'd0;
          dvs_d = b_abs;
          neg_q_d = reg2_i != 32'd0 && sdiv && (reg1_i[31] ^ reg2_i[31]);
          neg_r_d = reg2_i != 32'd0 && sdiv && reg1_i[31];
          state_d = reg2_i == 32'd0 ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        rem_d = diff[32] ? r33[31:0] : diff[31:0];
        quot_d = {quot_q[30:0], ~diff[32]};
        cnt_d = cnt_q + 6'd1;
        state_d = cnt_q == 6'(DIV_CYCLES - 1) ? DONE : BUSY;
      end
      DONE: begin
        hi_d = r_fin;
        lo_d = q_fin;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 6'd0;
      quot_q <= 32'd0;
      rem_q <= 32'd0;
      dvs_q <= 32'd0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      quot_q <= quot_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized self-checking bench for ex_stage against an arithmetic reference model
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst, flush, wr_en_i, ex_wr_en, stall_req;
  logic [7:0] aluop_i;
  logic [2:0] alusel_i;
  logic [31:0] reg1_i, reg2_i, ex_wdata, hi_o, lo_o;
  logic [4:0] waddr_i, ex_waddr;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  int n_chk = 0, n_pass = 0;
  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .waddr_i(waddr_i), .wr_en_i(wr_en_i),
    .ex_wr_en(ex_wr_en), .ex_wdata(ex_wdata), .ex_waddr(ex_waddr),
    .stall_req(stall_req), .hi_o(hi_o), .lo_o(lo_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      8'h24: return a & b;
      8'h25: return a | b;
      8'h26: return a ^ b;
      8'h27: return ~(a | b);
      8'h7C: return b << a[4:0];
      8'h02: return b >> a[4:0];
      8'h03: return sb >>> a[4:0];
      8'h21: return a + b;
      8'h23: return a - b;
      8'h2A: return sa < sb ? 32'd1 : 32'd0;
      8'h2B: return a < b ? 32'd1 : 32'd0;
      8'h10: return m_hi;
      8'h12: return m_lo;
      default: return 32'd0;
    endcase
  endfunction
  task automatic alu(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                     input logic wr, input logic [4:0] wa, input logic fl);
    logic exp_we;
    longint sp;
    longint unsigned up;
    int sa, sb;
    @(negedge clk);
    chk("hi", hi_o, m_hi);
    chk("lo", lo_o, m_lo);
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wr_en_i = wr; waddr_i = wa; flush = fl;
    #1;
    exp_we = wr && !fl && !(op inside {8'h18, 8'h19, 8'h1A, 8'h1B, 8'h11, 8'h13});
    chk("wdata", ex_wdata, ref_wdata(op, a, b));
    chk("wr_en", ex_wr_en, exp_we);
    chk("waddr", ex_waddr, wa);
    chk("stall", stall_req, 0);
    if (!fl) begin
      sa = a;
      sb = b;
      sp = longint'(sa) * longint'(sb);
      up = longint'(a) * longint'(b);
      if (op == 8'h18) {m_hi, m_lo} = sp;
      if (op == 8'h19) {m_hi, m_lo} = up;
      if (op == 8'h11) m_hi = a;
      if (op == 8'h13) m_lo = a;
    end
  endtask
  task automatic div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int abort_at, input logic abort_rst);
    logic [31:0] eq, er;
    longint q, r;
    int sa, sb, n;
    sa = a;
    sb = b;
    if (b == 0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
    end else if (op == 8'h1A) begin
      q = longint'(sa) / longint'(sb);
      r = longint'(sa) % longint'(sb);
      eq = q[31:0];
      er = r[31:0];
    end else begin
      eq = a / b;
      er = a % b;
    end
    @(negedge clk);
    chk("hi", hi_o, m_hi);
    chk("lo", lo_o, m_lo);
    aluop_i = op; alusel_i = 3'd4; reg1_i = a; reg2_i = b; wr_en_i = 1'b0; waddr_i = 5'd0; flush = 1'b0;
    #1;
    n = 0;
    while (stall_req === 1'b1 && n < 100) begin
      n++;
      if (n == abort_at) break;
      @(negedge clk);
      #1;
    end
    if (abort_at != 0) begin
      chk("abort_reach", n, abort_at);
      if (abort_rst) rst = 1'b1;
      else flush = 1'b1;
      #1;
      chk("abort_stall", stall_req, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; flush = 1'b0; aluop_i = 8'h00; alusel_i = 3'd0;
      #1;
      if (abort_rst) begin
        m_hi = 32'd0;
        m_lo = 32'd0;
      end
      chk("abort_hi", hi_o, m_hi);
      chk("abort_lo", lo_o, m_lo);
      chk("abort_idle", stall_req, 0);
    end else begin
      chk("div_stall", n, b == 0 ? 1 : 33);
      @(posedge clk);
      m_hi = er;
      m_lo = eq;
    end
  endtask
  logic [7:0] ops [18] = '{8'h00, 8'h24, 8'h25, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03, 8'h21,
                           8'h23, 8'h2A, 8'h2B, 8'h10, 8'h11, 8'h12, 8'h13, 8'h18, 8'h19};
  logic [2:0] sels [18] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd4,
                            3'd4, 3'd4, 3'd4, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4};
  function automatic logic [31:0] rnd();
    return $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 40)) : 32'($urandom);
  endfunction
  initial begin
    rst = 1'b1; flush = 1'b0; aluop_i = 8'h25; alusel_i = 3'd1; reg1_i = 32'hF0F0; reg2_i = 32'h0F0F;
    wr_en_i = 1'b1; waddr_i = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", ex_wr_en, 0);
    chk("rst_wdata", ex_wdata, 0);
    chk("rst_waddr", ex_waddr, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_stall", stall_req, 0);
    @(negedge clk);
    rst = 1'b0;
    alu(8'h00, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    alu(8'h25, 3'd1, 32'h0000F0F0, 32'h00000F0F, 1'b1, 5'd5, 1'b0);
    chk("or_const", ex_wdata, 32'h0000FFFF);
    chk("or_waddr", ex_waddr, 5);
    alu(8'h03, 3'd2, 32'd4, 32'h80000000, 1'b1, 5'd3, 1'b0);
    chk("sra_const", ex_wdata, 32'hF8000000);
    alu(8'h2A, 3'd4, 32'hFFFFFFFF, 32'd1, 1'b1, 5'd4, 1'b0);
    chk("slt_const", ex_wdata, 1);
    alu(8'h2B, 3'd4, 32'hFFFFFFFF, 32'd1, 1'b1, 5'd4, 1'b0);
    chk("sltu_const", ex_wdata, 0);
    alu(8'h18, 3'd4, 32'hFFFFFFFE, 32'd3, 1'b1, 5'd6, 1'b0);
    alu(8'h10, 3'd3, 32'h0, 32'h0, 1'b1, 5'd2, 1'b0);
    chk("mult_mfhi", ex_wdata, 32'hFFFFFFFF);
    chk("mult_lo", lo_o, 32'hFFFFFFFA);
    alu(8'h19, 3'd4, 32'hFFFFFFFE, 32'd3, 1'b1, 5'd6, 1'b0);
    alu(8'h00, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("multu_hi", hi_o, 32'h2);
    chk("multu_lo", lo_o, 32'hFFFFFFFA);
    alu(8'h13, 3'd3, 32'h1234, 32'h0, 1'b1, 5'd0, 1'b0);
    alu(8'h12, 3'd3, 32'h0, 32'h0, 1'b1, 5'd7, 1'b0);
    chk("mflo_const", ex_wdata, 32'h1234);
    div(8'h1A, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
    alu(8'h00, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("div_lo", lo_o, 32'hFFFFFFFD);
    chk("div_hi", hi_o, 32'hFFFFFFFF);
    div(8'h1B, 32'd100, 32'd7, 0, 1'b0);
    alu(8'h00, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("divu_lo", lo_o, 32'd14);
    chk("divu_hi", hi_o, 32'd2);
    div(8'h1A, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    alu(8'h00, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("intmin_lo", lo_o, 32'h80000000);
    chk("intmin_hi", hi_o, 32'h0);
    div(8'h1A, 32'd5, 32'd0, 0, 1'b0);
    alu(8'h00, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("dz_lo", lo_o, 32'hFFFFFFFF);
    chk("dz_hi", hi_o, 32'd5);
    div(8'h1B, 32'd1000, 32'd3, 11, 1'b0);
    div(8'h1B, 32'd9, 32'd4, 0, 1'b0);
    div(8'h1A, 32'd77, 32'd5, 20, 1'b1);
    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 17);
      alu(ops[k], sels[k], rnd(), rnd(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          $urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < 10; i++) begin
      div($urandom_range(0, 1) ? 8'h1A : 8'h1B, rnd(), $urandom_range(0, 3) == 0 ? 32'd0 : rnd(), 0, 1'b0);
      alu(8'h10, 3'd3, 32'h0, 32'h0, 1'b1, 5'd1, 1'b0);
      alu(8'h12, 3'd3, 32'h0, 32'h0, 1'b1, 5'd1, 1'b0);
    end
    alu(8'h00, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
